// File: rtl/dequantizer_array.sv
// dequantizer_array: N-lane signed-level to FP32 power-of-two dequantizer with a
// 2-stage valid/ready pipeline, per-lane bypass, sticky saturation flags and a beat counter.
module dequantizer_array #(
    parameter int NUM_LANES = 4,
    parameter int LEVEL_W   = 8,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_load_i,
    input  logic [7:0]                     scale_exp_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_LANES*LEVEL_W-1:0]   level_i,
    input  logic [NUM_LANES-1:0]           is_weight_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_LANES*32-1:0]        weight_fp_o,
    output logic                           sat_ovf_o,
    output logic                           sat_unf_o,
    output logic [CNT_W-1:0]               beat_count_o
);
    localparam int LZ_W = $clog2(LEVEL_W + 1);

    logic [7:0]                            scale_q, s1_scale_q;
    logic                                  s1_valid_q, out_valid_q, sat_ovf_q, sat_unf_q;
    logic [NUM_LANES-1:0]                  s1_sign_q, s1_byp_q, sign_d, ovf_d, unf_d;
    logic [NUM_LANES-1:0][LEVEL_W-1:0]     s1_mag_q, mag_d;
    logic [NUM_LANES-1:0][LZ_W-1:0]        s1_lz_q, lz_d;
    logic [NUM_LANES*32-1:0]               weight_q, weight_d;
    logic [CNT_W-1:0]                      cnt_q;
    logic                                  adv2;

    assign adv2         = !out_valid_q || out_ready_i;
    assign in_ready_o   = !s1_valid_q || adv2;
    assign out_valid_o  = out_valid_q;
    assign weight_fp_o  = weight_q;
    assign sat_ovf_o    = sat_ovf_q;
    assign sat_unf_o    = sat_unf_q;
    assign beat_count_o = cnt_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LEVEL_W-1:0] lvl, slvl;
        logic [LZ_W-1:0]    lz;
        logic signed [10:0] e;
        logic [22:0]        mant;
        logic               zero;
        assign lvl       = level_i[l*LEVEL_W +: LEVEL_W];
        assign sign_d[l] = lvl[LEVEL_W-1];
        assign mag_d[l]  = lvl[LEVEL_W-1] ? -lvl : lvl;
        always_comb begin
            lz = LZ_W'(LEVEL_W);
            for (int i = 0; i < LEVEL_W; i++)
                if (mag_d[l][i]) lz = LZ_W'(LEVEL_W - 1 - i);
        end
        assign lz_d[l] = lz;
        // e = (LEVEL_W-1-lz) + scale + 127, scale sign-extended into 11 bits
        assign e    = 11'(LEVEL_W + 126) - 11'(s1_lz_q[l]) + 11'($signed(s1_scale_q));
        assign mant = 23'(({s1_mag_q[l], 23'd0} << (s1_lz_q[l] + 1'b1)) >> LEVEL_W);
        assign slvl = s1_sign_q[l] ? -s1_mag_q[l] : s1_mag_q[l];
        assign zero = s1_mag_q[l] == '0;
        assign ovf_d[l] = !s1_byp_q[l] && !zero && e >= 11'sd255;
        assign unf_d[l] = !s1_byp_q[l] && !zero && e <= 11'sd0;
        assign weight_d[l*32 +: 32] =
            s1_byp_q[l] ? {{(32-LEVEL_W){slvl[LEVEL_W-1]}}, slvl} :
            zero        ? 32'h0 :
            ovf_d[l]    ? {s1_sign_q[l], 8'hFF, 23'h0} :
            unf_d[l]    ? {s1_sign_q[l], 31'h0} :
                          {s1_sign_q[l], e[7:0], mant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_scale_q  <= '0;
            s1_sign_q   <= '0;
            s1_byp_q    <= '0;
            s1_mag_q    <= '0;
            s1_lz_q     <= '0;
            out_valid_q <= 1'b0;
            weight_q    <= '0;
            sat_ovf_q   <= 1'b0;
            sat_unf_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (cfg_load_i) scale_q <= scale_exp_i;
            if (in_ready_o) s1_valid_q <= in_valid_i;
            if (in_ready_o && in_valid_i) begin
                s1_scale_q <= scale_q;
                s1_sign_q  <= sign_d;
                s1_byp_q   <= ~is_weight_i;
                s1_mag_q   <= mag_d;
                s1_lz_q    <= lz_d;
            end
            if (adv2) out_valid_q <= s1_valid_q;
            if (adv2 && s1_valid_q) begin
                weight_q  <= weight_d;
                sat_ovf_q <= sat_ovf_q || (|ovf_d);
                sat_unf_q <= sat_unf_q || (|unf_d);
            end
            if (out_valid_q && out_ready_i) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_dequantizer_array.sv
// tb_dequantizer_array: directed tests of conversion, saturation, bypass, scale timing,
// backpressure, counter wrap and asynchronous reset of dequantizer_array.
module tb_dequantizer_array;
    logic         clk = 1'b0, rst_n = 1'b0, cfg_load = 1'b0;
    logic [7:0]   scale_exp = '0;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0]  level = '0;
    logic [3:0]   is_weight = 4'hF;
    logic [127:0] weight;
    logic         sat_ovf, sat_unf;
    logic [3:0]   beat_count;
    int           checks = 0, errors = 0;

    dequantizer_array #(.NUM_LANES(4), .LEVEL_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load), .scale_exp_i(scale_exp),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .level_i(level), .is_weight_i(is_weight),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .weight_fp_o(weight),
        .sat_ovf_o(sat_ovf), .sat_unf_o(sat_unf), .beat_count_o(beat_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1; is_weight = 4'hF; level = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_scale(input logic [7:0] s);
        cfg_load = 1'b1; scale_exp = s;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [31:0] lv, input logic [3:0] w);
        level = lv; is_weight = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (weight !== 128'h0) begin errors++; $display("FAIL reset_weight: got %h expected 0", weight); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {sat_ovf, sat_unf}); end
        checks++; if (beat_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", beat_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_convert;
        do_reset;
        level = {8'd0, 8'd1, 8'h80, 8'd3}; is_weight = 4'hF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_latency1: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv_latency2: got %b expected 1", out_valid); end
        checks++; if (weight !== {32'h0, 32'h3F800000, 32'hC3000000, 32'h40400000}) begin
            errors++; $display("FAIL conv_weight: got %h expected %h", weight, {32'h0, 32'h3F800000, 32'hC3000000, 32'h40400000}); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b00) begin errors++; $display("FAIL conv_flags: got %b expected 00", {sat_ovf, sat_unf}); end
    endtask

    task automatic test_saturate;
        do_reset;
        set_scale(8'd127);
        send({24'd0, 8'd1}, 4'hF);
        checks++; if (weight !== {96'h0, 32'h7F000000}) begin errors++; $display("FAIL sat_max: got %h expected %h", weight, {96'h0, 32'h7F000000}); end
        checks++; if (sat_ovf !== 1'b0) begin errors++; $display("FAIL sat_max_flag: got %b expected 0", sat_ovf); end
        send({16'd0, 8'hFE, 8'd2}, 4'hF);
        checks++; if (weight !== {64'h0, 32'hFF800000, 32'h7F800000}) begin
            errors++; $display("FAIL sat_inf: got %h expected %h", weight, {64'h0, 32'hFF800000, 32'h7F800000}); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b10) begin errors++; $display("FAIL sat_ovf_flag: got %b expected 10", {sat_ovf, sat_unf}); end
        set_scale(8'h81);
        send({24'd0, 8'd1}, 4'hF);
        checks++; if (weight !== 128'h0) begin errors++; $display("FAIL sat_flush: got %h expected 0", weight); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b11) begin errors++; $display("FAIL sat_unf_flag: got %b expected 11", {sat_ovf, sat_unf}); end
        do_reset;
        set_scale(8'h80);
        send(32'd0, 4'hF);
        checks++; if (weight !== 128'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL sat_zero: got %h/%b expected 0/1", weight, out_valid); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b00) begin errors++; $display("FAIL sat_zero_flag: got %b expected 00", {sat_ovf, sat_unf}); end
    endtask

    task automatic test_scale_timing;
        do_reset;
        cfg_load = 1'b1; scale_exp = 8'd1; level = {24'd0, 8'd1}; is_weight = 4'hF; in_valid = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (weight[31:0] !== 32'h3F800000) begin errors++; $display("FAIL scale_old: got %h expected 3f800000", weight[31:0]); end
        @(negedge clk);
        checks++; if (weight[31:0] !== 32'h40000000) begin errors++; $display("FAIL scale_new: got %h expected 40000000", weight[31:0]); end
    endtask

    task automatic test_bypass;
        do_reset;
        send({8'd5, 8'hFF, 8'd5, 8'hFF}, 4'b0101);
        checks++; if (weight !== {32'd5, 32'hBF800000, 32'd5, 32'hBF800000}) begin
            errors++; $display("FAIL bypass_mix: got %h expected %h", weight, {32'd5, 32'hBF800000, 32'd5, 32'hBF800000}); end
        send({8'd0, 8'd127, 8'h80, 8'hFD}, 4'b1110);
        checks++; if (weight !== {32'h0, 32'h42FE0000, 32'hC3000000, 32'hFFFFFFFD}) begin
            errors++; $display("FAIL bypass_neg: got %h expected %h", weight, {32'h0, 32'h42FE0000, 32'hC3000000, 32'hFFFFFFFD}); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b00) begin errors++; $display("FAIL bypass_flags: got %b expected 00", {sat_ovf, sat_unf}); end
    endtask

    task automatic test_back_to_back;
        int sent = 0, rcv = 0, stalls = 0;
        do_reset;
        is_weight = 4'h0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid = sent < 6;
            level = {24'd0, 8'(sent + 1)};
            #1;
            if (in_valid && !in_ready) begin
                stalls++;
                checks++; if (sent - rcv != 2) begin errors++; $display("FAIL b2b_occupancy: got %0d expected 2", sent - rcv); end
            end
            if (out_valid && out_ready) begin
                checks++; if (weight[31:0] !== 32'(rcv + 1)) begin errors++; $display("FAIL b2b_order: got %h expected %h", weight[31:0], 32'(rcv + 1)); end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcv != 6) begin errors++; $display("FAIL b2b_received: got %0d expected 6", rcv); end
        checks++; if (stalls == 0) begin errors++; $display("FAIL b2b_stall: got %0d stalled cycles expected >0", stalls); end
        checks++; if (beat_count !== 4'd6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", beat_count); end
    endtask

    task automatic test_wrap;
        do_reset;
        is_weight = 4'hF; level = {24'd0, 8'd1}; in_valid = 1'b1;
        repeat (17) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (beat_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", beat_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_inflight;
        do_reset;
        send({24'd0, 8'd1}, 4'hF);
        set_scale(8'd127);
        out_ready = 1'b0; level = {24'd0, 8'd2}; in_valid = 1'b1;
        @(negedge clk);
        level = {24'd0, 8'd3};
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, sat_ovf} !== 2'b11 || beat_count !== 4'd1) begin
            errors++; $display("FAIL inflight_pre: got %b/%0d expected 11/1", {out_valid, sat_ovf}, beat_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || weight !== 128'h0) begin errors++; $display("FAIL inflight_out: got %b/%h expected 0/0", out_valid, weight); end
        checks++; if ({sat_ovf, sat_unf} !== 2'b00 || beat_count !== 4'd0) begin
            errors++; $display("FAIL inflight_state: got %b/%0d expected 00/0", {sat_ovf, sat_unf}, beat_count); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        level = {24'd0, 8'd1}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_lat1: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || weight !== {96'h0, 32'h3F800000}) begin
            errors++; $display("FAIL inflight_lat2: got %b/%h expected 1/%h", out_valid, weight, {96'h0, 32'h3F800000}); end
    endtask

    initial begin
        test_reset;
        test_convert;
        test_saturate;
        test_scale_timing;
        test_bypass;
        test_back_to_back;
        test_wrap;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
